// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus GPIO, cycle counter, optional down-timer.
// Define MMIO_TIMER_EN to build the TLOAD/TSTAT timer and timer_irq.
module dmem_mmio_responder #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  localparam int RAM_WORDS = 1 << ADDR_WIDTH;

  logic [31:0] r_ram [RAM_WORDS];
  logic [7:0]  r_gpio;
  logic [31:0] r_cycle;

  logic                  w_ram_sel;
  logic                  w_mmio_sel;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_off;
  logic                  w_wr_gpio;

  assign w_ram_sel  = (Mem_WrAddr >> (ADDR_WIDTH + 2)) == 32'd0;
  assign w_mmio_sel = Mem_WrAddr[31:4] == MMIO_BASE[31:4];
  assign w_idx      = Mem_WrAddr[ADDR_WIDTH+1:2];
  assign w_off      = Mem_WrAddr[3:2];
  assign w_wr_gpio  = MemWrite && w_mmio_sel && (w_off == 2'd0);

  // RAM is not reset and still accepts writes on a reset edge
  always_ff @(posedge clk) begin
    if (MemWrite && w_ram_sel)
      r_ram[w_idx] <= Mem_WrData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpio  <= 8'd0;
      r_cycle <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_wr_gpio)
        r_gpio <= Mem_WrData[7:0];
    end
  end

  assign gpio_out = r_gpio;

`ifdef MMIO_TIMER_EN
  logic [31:0] r_count;
  logic        r_expired;
  logic        w_wr_tload;
  logic        w_wr_tstat;
  logic        w_expire;

  assign w_wr_tload = MemWrite && w_mmio_sel && (w_off == 2'd2);
  assign w_wr_tstat = MemWrite && w_mmio_sel && (w_off == 2'd3);
  assign w_expire   = r_count == 32'd1;

  // Load beats expiry; expiry beats a status clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= 32'd0;
      r_expired <= 1'b0;
    end else if (w_wr_tload) begin
      r_count   <= Mem_WrData;
      r_expired <= 1'b0;
    end else begin
      if (r_count != 32'd0)
        r_count <= r_count - 32'd1;
      if (w_expire)
        r_expired <= 1'b1;
      else if (w_wr_tstat && Mem_WrData[0])
        r_expired <= 1'b0;
    end
  end

  assign timer_irq = r_expired;
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    ReadData = 32'd0;
    if (w_ram_sel) begin
      ReadData = r_ram[w_idx];
    end else if (w_mmio_sel) begin
      case (w_off)
        2'd0:    ReadData = {24'd0, r_gpio};
        2'd1:    ReadData = r_cycle;
`ifdef MMIO_TIMER_EN
        2'd2:    ReadData = r_count;
        2'd3:    ReadData = {30'd0, r_count != 32'd0, r_expired};
`endif
        default: ReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Vector-table bench for dmem_mmio_responder with an expected-result queue.
// Timer vectors follow MMIO_TIMER_EN, matching the DUT build.
module tb_dmem_mmio_responder;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  dmem_mmio_responder dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .ReadData   (ReadData),
    .gpio_out   (gpio_out),
    .timer_irq  (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] rd;
    logic [7:0]  gpio;
    logic        irq;
  } vec_t;

  vec_t tv[$];
  vec_t sb[$];
  int   n_vec;
  int   n_err;

  function automatic void add(logic rst, logic we, logic [31:0] addr,
                              logic [31:0] wdata, logic chk,
                              logic [31:0] rd, logic [7:0] gpio,
                              logic irq);
    vec_t v;
    v.rst = rst; v.we = we; v.addr = addr; v.wdata = wdata;
    v.chk = chk; v.rd = rd; v.gpio = gpio; v.irq = irq;
    tv.push_back(v);
  endfunction

  task automatic cmp(string name, int idx, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic step(int idx, vec_t v);
    vec_t e;
    @(negedge clk);
    reset      = v.rst;
    MemWrite   = v.we;
    Mem_WrAddr = v.addr;
    Mem_WrData = v.wdata;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    if (e.chk)
      cmp("rdata", idx, ReadData, e.rd);
    @(posedge clk);
    #1;
    cmp("gpio", idx, {24'd0, gpio_out}, {24'd0, e.gpio});
    cmp("irq", idx, {31'd0, timer_irq}, {31'd0, e.irq});
  endtask

  logic [31:0] c0, c1, c2;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    MemWrite = 1'b0;
    Mem_WrAddr = 32'd0;
    Mem_WrData = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_gpio", -1, {24'd0, gpio_out}, 32'd0);
    cmp("rst_irq", -1, {31'd0, timer_irq}, 32'd0);

    // rst we addr wdata chk rd gpio irq
    add(1, 0, 32'h1004, 0, 1, 32'h0, 8'h00, 0);
    add(0, 0, 32'h1000, 0, 1, 32'h0, 8'h00, 0);
    add(0, 1, 32'h0010, 32'h1111_1111, 0, 0, 8'h00, 0);
    add(0, 1, 32'h0010, 32'hDEAD_BEEF, 1, 32'h1111_1111, 8'h00, 0);
    add(0, 0, 32'h0010, 0, 1, 32'hDEAD_BEEF, 8'h00, 0);
    add(0, 0, 32'h0013, 0, 1, 32'hDEAD_BEEF, 8'h00, 0);
    add(0, 1, 32'h1000, 32'h0000_01A5, 1, 32'h0, 8'hA5, 0);
    add(0, 0, 32'h1000, 0, 1, 32'h0000_00A5, 8'hA5, 0);
    add(0, 1, 32'h0014, 32'h1234_5678, 0, 0, 8'hA5, 0);
    add(0, 0, 32'h0014, 0, 1, 32'h1234_5678, 8'hA5, 0);
    add(0, 1, 32'h00FC, 32'hCAFE_F00D, 0, 0, 8'hA5, 0);
    add(0, 0, 32'h00FC, 0, 1, 32'hCAFE_F00D, 8'hA5, 0);
    add(0, 1, 32'h0000, 32'h0000_A0A0, 0, 0, 8'hA5, 0);
    add(0, 1, 32'h0100, 32'h0000_0005, 1, 32'h0, 8'hA5, 0);
    add(0, 0, 32'h0000, 0, 1, 32'h0000_A0A0, 8'hA5, 0);
    add(0, 0, 32'h0100, 0, 1, 32'h0, 8'hA5, 0);
    add(0, 1, 32'h2000, 32'hFFFF_FFFF, 1, 32'h0, 8'hA5, 0);
    add(0, 0, 32'h2000, 0, 1, 32'h0, 8'hA5, 0);
    add(0, 0, 32'h1000, 0, 1, 32'h0000_00A5, 8'hA5, 0);
    add(0, 0, 32'h0010, 0, 1, 32'hDEAD_BEEF, 8'hA5, 0);
    add(0, 1, 32'h1010, 32'h0000_0077, 1, 32'h0, 8'hA5, 0);
    add(0, 0, 32'h1000, 0, 1, 32'h0000_00A5, 8'hA5, 0);
    add(1, 1, 32'h0020, 32'h0000_0077, 0, 0, 8'h00, 0);
    add(1, 1, 32'h1000, 32'h0000_00FF, 0, 0, 8'h00, 0);
    add(0, 0, 32'h0020, 0, 1, 32'h0000_0077, 8'h00, 0);
    add(0, 0, 32'h1000, 0, 1, 32'h0, 8'h00, 0);
    add(0, 1, 32'h1000, 32'h0000_003C, 1, 32'h0, 8'h3C, 0);
    foreach (tv[i]) step(i, tv[i]);
    tv.delete();

    @(negedge clk);
    MemWrite = 1'b0; Mem_WrAddr = 32'h1004;
    #1 c0 = ReadData;
    @(negedge clk);
    MemWrite = 1'b1; Mem_WrData = 32'h0;
    #1 c1 = ReadData;
    @(negedge clk);
    MemWrite = 1'b0;
    #1 c2 = ReadData;
    cmp("cycle_inc", -2, c1, c0 + 32'd1);
    cmp("cycle_ro", -3, c2, c0 + 32'd2);

`ifdef MMIO_TIMER_EN
    add(0, 1, 32'h1008, 32'd3, 1, 32'd0, 8'h3C, 0);
    add(0, 0, 32'h1008, 0, 1, 32'd3, 8'h3C, 0);
    add(0, 0, 32'h1008, 0, 1, 32'd2, 8'h3C, 0);
    add(0, 0, 32'h100C, 0, 1, 32'd2, 8'h3C, 1);
    add(0, 0, 32'h100C, 0, 1, 32'd1, 8'h3C, 1);
    add(0, 1, 32'h100C, 32'd2, 1, 32'd1, 8'h3C, 1);
    add(0, 1, 32'h100C, 32'd1, 1, 32'd1, 8'h3C, 0);
    add(0, 0, 32'h100C, 0, 1, 32'd0, 8'h3C, 0);
    add(0, 1, 32'h1008, 32'd1, 1, 32'd0, 8'h3C, 0);
    add(0, 1, 32'h100C, 32'd1, 1, 32'd2, 8'h3C, 1);
    add(0, 0, 32'h100C, 0, 1, 32'd1, 8'h3C, 1);
    add(0, 1, 32'h1008, 32'd1, 1, 32'd0, 8'h3C, 0);
    add(0, 1, 32'h1008, 32'd5, 1, 32'd1, 8'h3C, 0);
    add(0, 0, 32'h1008, 0, 1, 32'd5, 8'h3C, 0);
    add(0, 0, 32'h100C, 0, 1, 32'd2, 8'h3C, 0);
    add(0, 1, 32'h1008, 32'd0, 1, 32'd3, 8'h3C, 0);
    add(0, 0, 32'h100C, 0, 1, 32'd0, 8'h3C, 0);
    add(0, 0, 32'h1008, 0, 1, 32'd0, 8'h3C, 0);
    add(0, 1, 32'h1008, 32'd10, 0, 0, 8'h3C, 0);
    add(1, 0, 32'h1008, 0, 1, 32'd10, 8'h00, 0);
    add(0, 0, 32'h1008, 0, 1, 32'd0, 8'h00, 0);
    for (int k = 0; k < 12; k++)
      add(0, 0, 32'h100C, 0, 1, 32'd0, 8'h00, 0);
`else
    add(0, 0, 32'h1008, 0, 1, 32'd0, 8'h3C, 0);
    add(0, 1, 32'h1008, 32'd3, 1, 32'd0, 8'h3C, 0);
    add(0, 0, 32'h1008, 0, 1, 32'd0, 8'h3C, 0);
    for (int k = 0; k < 4; k++)
      add(0, 0, 32'h100C, 0, 1, 32'd0, 8'h3C, 0);
    add(0, 1, 32'h100C, 32'd1, 1, 32'd0, 8'h3C, 0);
    add(0, 0, 32'h1000, 0, 1, 32'h0000_003C, 8'h3C, 0);
`endif
    foreach (tv[i]) step(100 + i, tv[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
